sd_cmd_responder: RTL
=====================

// Module: sd_cmd_responder
// PURPOSE
//  Card-side SD CMD-line engine: the responder paired with commandManager (host initiator).
//  Deserialises 48-bit host command frames from SD_CMD, checks framing and CRC7, and presents
//  index/argument to card logic. It then serialises the R1/R3/R6/R7 (48-bit) or R2 (136-bit)
//  response card logic supplies. Used as a synthesizable card model and for sdModel cross-check.
// PARAMETERS
//  NCR      2   min SD_CLK cycles between command end bit and response start bit (>=2)
//  NCR_MAX  64  cycles to wait for RSP_VALID before abandoning the response
// PORTS
//  SD_CLK       in   1    SD clock; all state on rising edge
//  RST          in   1    asynchronous, active-low reset
//  CMD_IN       in   1    sampled CMD line (pulled up when undriven)
//  CMD_OUT      out  1    CMD drive value (registered)
//  CMD_OE       out  1    CMD output enable (registered; tristate at top)
//  CMD_VALID    out  1    one-cycle pulse: command frame received
//  CMD_INDEX    out  6    command index, held until next frame
//  CMD_ARG      out  32   command argument, held until next frame
//  CMD_CRC_ERR  out  1    qualifies CMD_VALID: received CRC7 mismatch
//  FRAME_ERR    out  1    one-cycle pulse: bad transmission or end bit, frame dropped
//  RSP_VALID    in   1    card logic offers response (sampled in WAIT only)
//  RSP_TYPE     in   2    00 none, 01 48-bit+CRC7 (R1/R6/R7), 10 R2 136-bit, 11 R3 (CRC=7'h7F)
//  RSP_INDEX    in   6    index field for 48-bit types (R2 forces 6'h3F)
//  RSP_DATA     in   120  48-bit types use [31:0]; R2 uses [119:0] (CID/CSD[127:8])
//  RSP_BUSY     out  1    high from response start bit through end bit
//  RSP_DONE     out  1    one-cycle pulse after response end bit driven
// BEHAVIOUR
//  Reset: CMD_OE=0, CMD_OUT=1, CMD_VALID=0, CMD_INDEX=0, CMD_ARG=0, CMD_CRC_ERR=0,
//   FRAME_ERR=0, RSP_BUSY=0, RSP_DONE=0, state IDLE. Mid-frame reset releases line at once.
//  Frame, MSB first: start 0 | tx bit | 6 index | 32 arg | 7 CRC | end 1.
//  CRC7: G=x^7+x^3+1, init 0. Covers first 40 bits (48-bit) or RSP_DATA 120 bits (R2).
//  FSM:
//   IDLE  : CMD_IN=0 sampled -> RX, bit count 1.
//   RX    : shift 47 more bits. At end bit (edge E0) check tx bit==1 and end==1.
//           Fail -> FRAME_ERR pulse, IDLE. Pass -> latch index/arg, CMD_CRC_ERR=mismatch,
//           CMD_VALID for the cycle after E0, -> WAIT.
//   WAIT  : count cycles from E0. RSP_VALID with type 00 -> IDLE.
//           Other types: latch type/index/data, compute CRC, -> NCR.
//           No RSP_VALID by count NCR_MAX -> IDLE silently. CMD_IN ignored.
//   NCR   : hold line released. Start bit driven (OE=1, OUT=0) on edge
//           max(E0+NCR, Ev+1), Ev = edge RSP_VALID sampled.
//   TX    : shift 48 or 136 bits. Transmission bit 0. R2 index field 6'h3F.
//           R3 CRC field 7'h7F. End bit 1.
//   DONE  : edge after end bit: OE=0, RSP_DONE pulse, -> IDLE. Next start bit accepted same cycle.
//  Line may be re-driven by host only after OE falls. Starts on CMD_IN never sampled while OE=1.
//  CMD_CRC_ERR does not suppress WAIT; card logic answers with type 00 to stay silent.
//  Counters: 8-bit bit/cycle counter, saturating, reused per state.
// STRUCTURE
//  sd_cmd_pkg: frame lengths (48, 136), RSP_TYPE encodings, state encodings, CRC7 poly 7'h09.
//  Sub-module sd_crc7: serial CRC7 (CLR, ENA, BIT_IN, CRC[6:0]).
//   One instance on RX path; one on TX path, fed during TX shift.
//  Shift registers: 48-bit RX, 136-bit TX (loaded on entry to NCR).
// TESTING
//  1 CMD0 frame 48'h40_0000_0000_95 -> CMD_VALID, INDEX=0, ARG=0, CRC_ERR=0; RSP type 00 -> OE stays 0.
//  2 CMD8 48'h48_0000_01AA_87, RSP type 01 idx 8 data 32'h1AA at once
//    -> start bit at E0+2, line carries 48'h08_0000_01AA_13, RSP_DONE.
//  3 ACMD41 reply type 11 data 32'h80FF8000 -> 48'h3F_80FF_8000_FF on CMD.
//  4 CMD0 with CRC byte 8'h97 -> CMD_CRC_ERR=1; frame with end bit 0 -> FRAME_ERR, no CMD_VALID.
//  5 CMD2 + R2 type 10 data 120'h0123..: 136 bits, index field 3F, CRC7 matches reference model;
//    no RSP_VALID within 64 cycles -> IDLE, OE never set.
//  6 Assert RST mid-TX -> OE=0 same cycle; after release, CMD0 decodes normally.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// Shared encodings and constants for the card-side SD CMD-line responder.
package sd_cmd_pkg;

    localparam int         FRAME_LEN_48  = 48;
    localparam int         FRAME_LEN_136 = 136;
    localparam logic [6:0] CRC7_POLY     = 7'h09;
    localparam logic [5:0] R2_INDEX      = 6'h3F;
    localparam logic [6:0] R3_CRC        = 7'h7F;

    typedef enum logic [1:0] {
        RSP_NONE = 2'b00,
        RSP_48   = 2'b01,
        RSP_R2   = 2'b10,
        RSP_R3   = 2'b11
    } rsp_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_WAIT,
        ST_NCR,
        ST_TX,
        ST_DONE
    } state_e;

    function automatic logic [7:0] frame_len(input rsp_type_e t);
        return (t == RSP_R2) ? 8'(FRAME_LEN_136) : 8'(FRAME_LEN_48);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), zero initial value, MSB-first input.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       ena,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic fb;

    assign fb = bit_in ^ crc[6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (ena) begin
            crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD engine: receives 48-bit host commands, then serialises the
// 48-bit or 136-bit response offered by card logic.
module sd_cmd_responder
    import sd_cmd_pkg::*;
#(
    parameter int NCR     = 2,
    parameter int NCR_MAX = 64
) (
    input  logic         sd_clk,
    input  logic         rst_n,
    input  logic         cmd_in,
    output logic         cmd_out,
    output logic         cmd_oe,
    output logic         cmd_valid,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    output logic         cmd_crc_err,
    output logic         frame_err,
    input  logic         rsp_valid,
    input  logic [1:0]   rsp_type,
    input  logic [5:0]   rsp_index,
    input  logic [119:0] rsp_data,
    output logic         rsp_busy,
    output logic         rsp_done
);

    localparam logic [7:0] NCR_C     = 8'(NCR);
    localparam logic [7:0] NCR_MAX_C = 8'(NCR_MAX);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    rsp_type_e   rtype_q, rtype_d;

    logic        oe_d, out_d, valid_d, crc_err_d, ferr_d, busy_d, done_d;
    logic [5:0]  index_d;
    logic [31:0] arg_d;

    // Start bit is never stored; idx k of the frame sits at rx_sr[46-k] at the end bit.
    logic [45:0]  rx_sr;
    logic [135:0] tx_sr;
    logic         load_tx, shift_tx;

    logic         rx_crc_clr, rx_crc_ena;
    logic [6:0]   rx_crc;
    logic         tx_crc_clr, tx_crc_ena;
    logic [6:0]   tx_crc;

    logic [7:0]   tx_len, crc_lo, cov_lo;
    logic [2:0]   crc_off;

    sd_crc7 u_rx_crc (
        .clk    (sd_clk),
        .rst_n  (rst_n),
        .clr    (rx_crc_clr),
        .ena    (rx_crc_ena),
        .bit_in (cmd_in),
        .crc    (rx_crc)
    );

    sd_crc7 u_tx_crc (
        .clk    (sd_clk),
        .rst_n  (rst_n),
        .clr    (tx_crc_clr),
        .ena    (tx_crc_ena),
        .bit_in (tx_sr[135]),
        .crc    (tx_crc)
    );

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign tx_len  = frame_len(rtype_q);
    assign crc_lo  = tx_len - 8'd8;
    assign cov_lo  = (rtype_q == RSP_R2) ? 8'd8 : 8'd0;
    assign crc_off = 3'(cnt_q - crc_lo);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rtype_d    = rtype_q;
        oe_d       = cmd_oe;
        out_d      = cmd_out;
        valid_d    = 1'b0;
        index_d    = cmd_index;
        arg_d      = cmd_arg;
        crc_err_d  = cmd_crc_err;
        ferr_d     = 1'b0;
        busy_d     = rsp_busy;
        done_d     = 1'b0;
        load_tx    = 1'b0;
        shift_tx   = 1'b0;
        rx_crc_clr = (state_q == ST_IDLE);
        rx_crc_ena = 1'b0;
        tx_crc_clr = 1'b0;
        tx_crc_ena = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!cmd_in) begin
                    state_d = ST_RX;
                    cnt_d   = 8'd1;
                end
            end
            ST_RX: begin
                rx_crc_ena = (cnt_q < 8'd40);
                if (cnt_q == 8'd47) begin
                    if (rx_sr[45] && cmd_in) begin
                        valid_d   = 1'b1;
                        index_d   = rx_sr[44:39];
                        arg_d     = rx_sr[38:7];
                        crc_err_d = (rx_crc != rx_sr[6:0]);
                        state_d   = ST_WAIT;
                        cnt_d     = 8'd1;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT: begin
                // cnt_q equals the number of edges since the command end bit.
                cnt_d = cnt_inc;
                if (rsp_valid) begin
                    if (rsp_type == RSP_NONE) begin
                        state_d = ST_IDLE;
                    end else begin
                        rtype_d = rsp_type_e'(rsp_type);
                        load_tx = 1'b1;
                        state_d = ST_NCR;
                    end
                end else if (cnt_q >= NCR_MAX_C) begin
                    state_d = ST_IDLE;
                end
            end
            ST_NCR: begin
                tx_crc_clr = 1'b1;
                if (cnt_q >= NCR_C) begin
                    oe_d     = 1'b1;
                    out_d    = tx_sr[135];
                    busy_d   = 1'b1;
                    shift_tx = 1'b1;
                    state_d  = ST_TX;
                    cnt_d    = 8'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_TX: begin
                // cnt_q is the frame position being driven on this edge.
                cnt_d = cnt_inc;
                if (cnt_q < crc_lo) begin
                    out_d      = tx_sr[135];
                    shift_tx   = 1'b1;
                    tx_crc_ena = (cnt_q >= cov_lo);
                end else if (cnt_q < tx_len - 8'd1) begin
                    out_d = (rtype_q == RSP_R3) ? R3_CRC[3'd6 - crc_off]
                                                : tx_crc[3'd6 - crc_off];
                end else begin
                    out_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                oe_d    = 1'b0;
                out_d   = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rtype_q     <= RSP_NONE;
            cmd_oe      <= 1'b0;
            cmd_out     <= 1'b1;
            cmd_valid   <= 1'b0;
            cmd_index   <= '0;
            cmd_arg     <= '0;
            cmd_crc_err <= 1'b0;
            frame_err   <= 1'b0;
            rsp_busy    <= 1'b0;
            rsp_done    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rtype_q     <= rtype_d;
            cmd_oe      <= oe_d;
            cmd_out     <= out_d;
            cmd_valid   <= valid_d;
            cmd_index   <= index_d;
            cmd_arg     <= arg_d;
            cmd_crc_err <= crc_err_d;
            frame_err   <= ferr_d;
            rsp_busy    <= busy_d;
            rsp_done    <= done_d;
        end
    end

    // CRC field and end bit are produced on the fly; the low byte loaded here is never driven.
    always_ff @(posedge sd_clk) begin
        if (state_q == ST_IDLE || state_q == ST_RX) begin
            rx_sr <= {rx_sr[44:0], cmd_in};
        end
        if (load_tx) begin
            if (rsp_type == RSP_R2) begin
                tx_sr <= {2'b00, R2_INDEX, rsp_data, 8'h01};
            end else begin
                tx_sr <= {2'b00, rsp_index, rsp_data[31:0], 8'h01, 88'h0};
            end
        end else if (shift_tx) begin
            tx_sr <= {tx_sr[134:0], 1'b0};
        end
    end

endmodule
